sysid_info_regs: RTL and testbench

SYSID_INFO_REGS -- requirements
Module: sysid_info_regs

---
 rtl/sysid_pkg.sv | 37 +++
 rtl/sysid_uptime_counter.sv | 51 +++++
 rtl/sysid_info_regs.sv | 117 +++++++++++
 tb/tb_sysid_info_regs.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// -----------------------------------------------------------------------------
// sysid_pkg
// Shared definitions for the system-ID / info register block: data width,
// register word offsets, CONTROL bit positions and a byte-lane merge helper.
// -----------------------------------------------------------------------------
package sysid_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef logic [DATA_W-1:0] word_t;

    // Register word offsets
    localparam int unsigned OFS_ID          = 32'd0;
    localparam int unsigned OFS_TIMESTAMP   = 32'd1;
    localparam int unsigned OFS_UPTIME_LO   = 32'd2;
    localparam int unsigned OFS_UPTIME_HI   = 32'd3;
    localparam int unsigned OFS_CONTROL     = 32'd4;
    localparam int unsigned OFS_PARAM       = 32'd5;
    localparam int unsigned OFS_SCRATCH     = 32'd8;

    // CONTROL bit indices
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    // Replace only the byte lanes whose enable bit is set.
    function automatic word_t merge_bytes(input word_t old_w,
                                          input word_t new_w,
                                          input logic [BE_W-1:0] be);
        word_t res;
        for (int b = 0; b < BE_W; b++) begin
            res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// -----------------------------------------------------------------------------
// sysid_uptime_counter
// 64-bit free-running uptime counter with a high-word snapshot register.
// Reading the low word (snap) captures the high word on the same edge so a
// LO-then-HI read pair yields a coherent 64-bit value.
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset (count and snapshot -> 0)
//   en       in   increment enable
//   clr      in   zero count and snapshot; has priority over en and snap
//   snap     in   latch count[63:32] into the snapshot register
//   count_lo out  count[31:0] (live)
//   snap_hi  out  snapshot of count[63:32]
// -----------------------------------------------------------------------------
module sysid_uptime_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic        snap,
    output logic [31:0] count_lo,
    output logic [31:0] snap_hi
);

    logic [63:0] count;
    logic [31:0] hi_snap;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; count[63:32] here is the value before increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            hi_snap <= '0;
        end else if (clr) begin
            count   <= '0;
            hi_snap <= '0;
        end else begin
            if (en) begin
                count <= count + 64'd1;  // wraps silently at 2**64-1
            end
            if (snap) begin
                hi_snap <= count[63:32];
            end
        end
    end

    assign count_lo = count[31:0];
    assign snap_hi  = hi_snap;

endmodule

// File: rtl/sysid_info_regs.sv
// -----------------------------------------------------------------------------
// sysid_info_regs
// Avalon-MM slave exposing system identification, build timestamp, a 64-bit
// uptime counter, a CONTROL register and NUM_SCRATCH read/write scratch words.
// No waitrequest; fixed read latency of one cycle.
//
// Map (word offsets)
//   0 ID (RO)  1 TIMESTAMP (RO)  2 UPTIME_LO (RO, snapshots high word)
//   3 UPTIME_HI_SNAP (RO)  4 CONTROL (RW: [0] EN, [1] CLR self-clearing)
//   5 PARAM (RO)  6-7 reserved  8.. SCRATCH (RW)
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   synchronous active-high reset
//   address        in   word address [ADDR_W-1:0]
//   read           in   read request
//   write          in   write request
//   writedata      in   write data [31:0]
//   byteenable     in   per-byte write enable [3:0]
//   readdata       out  registered read data [31:0]
//   readdatavalid  out  one-cycle pulse qualifying readdata
// -----------------------------------------------------------------------------
module sysid_info_regs
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID       = 32'h0000_0000,
    parameter logic [31:0] BUILD_TIMESTAMP = 32'd1447815554,
    parameter int          NUM_SCRATCH     = 4,
    parameter int          ADDR_W          = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    logic [31:0] addr_ext;
    word_t       scratch [NUM_SCRATCH];
    logic        ctrl_en;
    logic        ctrl_wr;
    logic        clr_pulse;
    logic        snap_req;
    logic [31:0] uptime_lo;
    logic [31:0] uptime_hi_snap;
    word_t       rd_word;

    assign addr_ext = 32'(address);

    // CLR lives in byte lane 0, so it only fires when that lane is enabled.
    assign ctrl_wr   = write && (addr_ext == OFS_CONTROL);
    assign clr_pulse = ctrl_wr && byteenable[0] && writedata[CTRL_CLR_BIT];
    assign snap_req  = read && (addr_ext == OFS_UPTIME_LO);

    sysid_uptime_counter u_uptime (
        .clock    (clock),
        .reset    (reset),
        .en       (ctrl_en),
        .clr      (clr_pulse),
        .snap     (snap_req),
        .count_lo (uptime_lo),
        .snap_hi  (uptime_hi_snap)
    );

    // Read mux works on pre-edge state, so a same-cycle write or CLR is not
    // visible in the returned word.
    // NOTE: rd_word gets a default before the case/loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_word = '0;
        case (addr_ext)
            OFS_ID:        rd_word = SYSTEM_ID;
            OFS_TIMESTAMP: rd_word = BUILD_TIMESTAMP;
            OFS_UPTIME_LO: rd_word = uptime_lo;
            OFS_UPTIME_HI: rd_word = uptime_hi_snap;
            OFS_CONTROL:   rd_word = {30'b0, 1'b0, ctrl_en};  // CLR reads 0
            OFS_PARAM:     rd_word = {24'b0, 8'(NUM_SCRATCH)};
            default:       rd_word = '0;
        endcase
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (addr_ext == OFS_SCRATCH + 32'(i)) begin
                rd_word = scratch[i];
            end
        end
    end

    // NOTE: the scratch words are a handful of flops, not a RAM, and must
    // read 0 after reset, so they are reset explicitly in a loop.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            ctrl_en       <= 1'b1;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch[i] <= '0;
            end
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_word;
            end
            if (ctrl_wr && byteenable[0]) begin
                ctrl_en <= writedata[CTRL_EN_BIT];
            end
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (write && (addr_ext == OFS_SCRATCH + 32'(i))) begin
                    scratch[i] <= merge_bytes(scratch[i], writedata, byteenable);
                end
            end
        end
    end

endmodule

// File: tb/tb_sysid_info_regs.sv
// -----------------------------------------------------------------------------
// tb_sysid_info_regs
// Directed stimulus with a scoreboard: every driven cycle pushes the expected
// readdatavalid/readdata for the following cycle; a monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_sysid_info_regs;

    logic        clock;
    logic        reset;
    logic [3:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    typedef struct {
        logic        v;
        logic [31:0] d;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] last_d;
    int          checks;
    int          errors;

    sysid_info_regs dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One bus cycle. The expectation is pushed once the edge has sampled the
    // inputs; the response is due before the next edge.
    task automatic bus(input logic rst, input logic rd, input logic wr,
                       input logic [3:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] exp_d,
                       input string nm);
        exp_t e;
        reset      = rst;
        read       = rd;
        write      = wr;
        address    = a;
        writedata  = wd;
        byteenable = be;
        @(posedge clock);
        if (rst)     last_d = 32'h0;
        else if (rd) last_d = exp_d;
        e.v    = rd && !rst;
        e.d    = last_d;
        e.name = nm;
        exp_q.push_back(e);
        #1;
        reset      = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = 4'h0;
        writedata  = 32'h0;
        byteenable = 4'h0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp_d, input string nm);
        bus(1'b0, 1'b1, 1'b0, a, 32'h0, 4'h0, exp_d, nm);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
        bus(1'b0, 1'b0, 1'b1, a, wd, be, 32'h0, "write");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0, "idle_hold");
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        wait (exp_q.size() > 0);
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (readdatavalid !== e.v || readdata !== e.d) begin
                    errors++;
                    $display("FAIL %s: got valid=%0b data=%08h, expected valid=%0b data=%08h",
                             e.name, readdatavalid, readdata, e.v, e.d);
                end
            end else if (readdatavalid !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid=%0b, expected valid=0", readdatavalid);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        last_d = 32'h0;
        reset = 1'b1; read = 1'b0; write = 1'b0;
        address = 4'h0; writedata = 32'h0; byteenable = 4'h0;

        bus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0, "reset_state");
        bus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 32'h0, "reset_state");

        // Identification registers
        rd(4'd0, 32'h0000_0000, "id");
        rd(4'd1, 32'd1447815554, "timestamp");
        rd(4'd5, 32'h0000_0004, "param");
        idle(1);
        rd(4'd4, 32'h0000_0001, "control_reset");
        rd(4'd3, 32'h0000_0000, "hi_snap_reset");

        // Scratch byte lanes, out-of-range scratch address
        wr(4'd8, 32'hDEAD_BEEF, 4'b0011);
        rd(4'd8, 32'h0000_BEEF, "scratch8_be0011");
        rd(4'd12, 32'h0000_0000, "addr12_unmapped");

        // Read and write same cycle returns old value
        wr(4'd9, 32'h0000_0011, 4'b1111);
        bus(1'b0, 1'b1, 1'b1, 4'd9, 32'h0000_0022, 4'b1111, 32'h0000_0011, "rdwr_old_value");
        rd(4'd9, 32'h0000_0022, "rdwr_new_value");
        wr(4'd9, 32'hFFFF_FFFF, 4'b0000);
        rd(4'd9, 32'h0000_0022, "scratch_be0000");
        wr(4'd9, 32'hAABB_CCDD, 4'b1010);
        rd(4'd9, 32'hAA00_CC22, "scratch_be1010");

        // RO and reserved registers ignore writes
        wr(4'd0, 32'hFFFF_FFFF, 4'b1111);
        rd(4'd0, 32'h0000_0000, "id_ro");
        wr(4'd6, 32'h0000_1234, 4'b1111);
        rd(4'd6, 32'h0000_0000, "reserved6");
        rd(4'd15, 32'h0000_0000, "addr15_unmapped");
        wr(4'd5, 32'h0000_0000, 4'b1111);
        rd(4'd5, 32'h0000_0004, "param_ro");

        // Low word at all-ones: snapshot must hold the pre-carry high word
        force dut.u_uptime.count = 64'h0000_0000_FFFF_FFFF;
        rd(4'd2, 32'hFFFF_FFFF, "uptime_lo_ffffffff");
        release dut.u_uptime.count;
        rd(4'd3, 32'h0000_0000, "uptime_hi_snap_carry");

        // CLR + EN, then counting
        wr(4'd4, 32'h0000_0003, 4'b1111);
        rd(4'd2, 32'h0000_0000, "uptime_after_clr");
        rd(4'd2, 32'h0000_0001, "uptime_inc1");
        idle(3);
        rd(4'd2, 32'h0000_0005, "uptime_inc5");

        // Disable counting
        wr(4'd4, 32'h0000_0000, 4'b1111);
        rd(4'd2, 32'h0000_0007, "uptime_stopped_a");
        idle(9);
        rd(4'd2, 32'h0000_0007, "uptime_stopped_b");
        rd(4'd4, 32'h0000_0000, "control_en0");
        wr(4'd4, 32'h0000_0003, 4'b1110);
        rd(4'd4, 32'h0000_0000, "control_lane0_off");
        rd(4'd2, 32'h0000_0007, "uptime_no_clr");
        wr(4'd4, 32'h0000_0001, 4'b0001);
        rd(4'd4, 32'h0000_0001, "control_en1");

        // Read presented during reset is discarded
        bus(1'b1, 1'b1, 1'b0, 4'd8, 32'h0, 4'h0, 32'h0, "reset_during_read");
        rd(4'd2, 32'h0000_0000, "uptime_post_reset0");
        rd(4'd2, 32'h0000_0001, "uptime_post_reset1");
        rd(4'd3, 32'h0000_0000, "hi_snap_post_reset");
        rd(4'd8, 32'h0000_0000, "scratch8_post_reset");
        rd(4'd9, 32'h0000_0000, "scratch9_post_reset");
        rd(4'd4, 32'h0000_0001, "control_post_reset");
        idle(2);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clock);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
